// File: rtl/fir_sample_feeder.sv
// Buffers ADC samples in a FIFO and issues them one at a time to the FIR control (enable pulse, wait for done),
// granting host configuration only between samples. Define FEEDER_TIMEOUT_EN to build the done watchdog.
module fir_sample_feeder #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          adc_valid,
  input  logic [DATA_W-1:0]             adc_data,
  output logic                          adc_ready,
  input  logic                          cfg_req,
  output logic                          cfg_busy,
  output logic                          fir_enable,
  output logic [DATA_W-1:0]             fir_sample,
  output logic                          fir_configuration,
  input  logic                          fir_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          timeout_err,
  input  logic                          clr_err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ISSUE     = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;
  localparam logic [1:0] CONFIG    = 2'd3;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT < 2) begin : g_param_check
    $error("fir_sample_feeder: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT >= 2");
  end

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              timeout_hit;

  // count never exceeds FIFO_DEPTH, so its MSB alone marks full
  assign full       = count[AW];
  assign empty      = (count == '0);
  assign adc_ready  = !full;
  assign push       = adc_valid && !full;
  assign pop        = (state == IDLE) && !cfg_req && !empty;
  assign fifo_level = count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= adc_data;
  end

`ifdef FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);

  logic [TW-1:0] wd_cnt;

  // a done arriving on the final watchdog cycle wins over the timeout
  assign timeout_hit = (state == WAIT_DONE) && !fir_done && (wd_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)                              wd_cnt <= '0;
    else if (state == ISSUE)                 wd_cnt <= '0;
    else if (state == WAIT_DONE && !fir_done) wd_cnt <= wd_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)           timeout_err <= 1'b0;
    else if (timeout_hit) timeout_err <= 1'b1;
    else if (clr_err)     timeout_err <= 1'b0;
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cfg_req)     state_nxt = CONFIG;
        else if (!empty) state_nxt = ISSUE;
      end
      ISSUE:     state_nxt = WAIT_DONE;
      WAIT_DONE: if (fir_done || timeout_hit) state_nxt = IDLE;
      CONFIG:    if (!cfg_req) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      fir_sample <= '0;
    end else begin
      state <= state_nxt;
      if (pop) fir_sample <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                  overflow <= 1'b0;
    else if (adc_valid && full)  overflow <= 1'b1;
    else if (clr_err)            overflow <= 1'b0;
  end

  assign fir_enable        = (state == ISSUE);
  assign fir_configuration = (state == CONFIG);
  assign cfg_busy          = (state == CONFIG);

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Directed phases plus a randomized run, checked every cycle against a transaction-level model of the feeder.
module tb_fir_sample_feeder;
  localparam int DATA_W  = 16;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 64;
  localparam int LW      = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, adc_valid, adc_ready, cfg_req, cfg_busy, fir_enable;
  logic              fir_configuration, fir_done, overflow, timeout_err, clr_err;
  logic [DATA_W-1:0] adc_data, fir_sample;
  logic [LW-1:0]     fifo_level;

  fir_sample_feeder #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .adc_valid(adc_valid), .adc_data(adc_data), .adc_ready(adc_ready),
    .cfg_req(cfg_req), .cfg_busy(cfg_busy), .fir_enable(fir_enable), .fir_sample(fir_sample),
    .fir_configuration(fir_configuration), .fir_done(fir_done), .fifo_level(fifo_level),
    .overflow(overflow), .timeout_err(timeout_err), .clr_err(clr_err)
  );

  int checks = 0;
  int errors = 0;

  // stimulus knobs read by tick()
  bit          s_valid, s_cfg, s_clr, s_rst, s_spur;
  logic [15:0] s_data;
  int          s_lat;

  // reference model: queue of buffered samples, one in-flight transaction, config grant
  logic [15:0] q[$];
  bit          m_cfg, m_inflight;
  int          m_en_cyc, m_wait, cyc;
  logic [15:0] exp_sample;
  bit          exp_ovf, exp_to;
  int          en_log[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    bit waiting, done, push, ovf_set, to_set;
    @(negedge clk);
    chk("fir_enable", fir_enable, m_inflight && cyc == m_en_cyc);
    chk("fir_configuration", fir_configuration, m_cfg);
    chk("cfg_busy", cfg_busy, m_cfg);
    chk("fir_sample", fir_sample, exp_sample);
    chk("fifo_level", fifo_level, q.size());
    chk("adc_ready", adc_ready, q.size() < DEPTH);
    chk("overflow", overflow, exp_ovf);
    chk("timeout_err", timeout_err, exp_to);
    if (fir_enable === 1'b1) en_log.push_back(cyc);

    // filter responder: done s_lat cycles after the enable, plus optional stray pulses when idle
    waiting = m_inflight && cyc > m_en_cyc;
    done    = (waiting && (cyc - m_en_cyc) >= s_lat) || (s_spur && !waiting);
    rst_n     = !s_rst;
    adc_valid = s_valid;
    adc_data  = s_data;
    cfg_req   = s_cfg;
    clr_err   = s_clr;
    fir_done  = done;

    if (s_rst) begin
      q.delete();
      m_cfg = 0; m_inflight = 0; m_en_cyc = -1;
      exp_sample = '0; exp_ovf = 0; exp_to = 0;
    end else begin
      push    = s_valid && q.size() < DEPTH;
      ovf_set = s_valid && q.size() == DEPTH;
      to_set  = 0;
      if (!m_cfg && !m_inflight) begin
        if (s_cfg) m_cfg = 1;
        else if (q.size() != 0) begin
          exp_sample = q.pop_front();
          m_inflight = 1;
          m_en_cyc   = cyc + 1;
          m_wait     = 0;
        end
      end else if (m_cfg) begin
        if (!s_cfg) m_cfg = 0;
      end else if (waiting) begin
        if (done) m_inflight = 0;
        else begin
          m_wait++;
`ifdef FEEDER_TIMEOUT_EN
          if (m_wait == TIMEOUT) begin
            m_inflight = 0;
            to_set     = 1;
          end
`endif
        end
      end
      if (push) q.push_back(s_data);
      exp_ovf = ovf_set || (exp_ovf && !s_clr);
      exp_to  = to_set  || (exp_to  && !s_clr);
    end
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic push1(input logic [15:0] d);
    s_valid = 1; s_data = d;
    tick();
    s_valid = 0;
  endtask

  int p, e0;

  initial begin
    s_valid = 0; s_cfg = 0; s_clr = 0; s_rst = 0; s_spur = 0; s_data = '0; s_lat = 5;
    rst_n = 0; adc_valid = 0; adc_data = '0; cfg_req = 0; clr_err = 0; fir_done = 0;
    q.delete(); m_cfg = 0; m_inflight = 0; m_en_cyc = -1; m_wait = 0;
    exp_sample = '0; exp_ovf = 0; exp_to = 0; cyc = 0;
    repeat (2) @(posedge clk);
    s_rst = 1; tick(); s_rst = 0;
    run(2);

    // single sample, done 5 cycles after enable
    en_log.delete();
    p = cyc;
    push1(16'h1234);
    run(12);
    e0 = (en_log.size() > 0) ? en_log[0] : -100;
    chk("single_enable_count", en_log.size(), 1);
    chk("single_latency", e0 - p, 2);
    chk("single_sample", fir_sample, 16'h1234);
    chk("single_level", fifo_level, 0);

    // back-to-back, done 6 cycles after enable -> 8-cycle sample period
    en_log.delete();
    s_lat = 6;
    for (int i = 1; i <= 4; i++) push1(16'(i));
    run(40);
    chk("b2b_enable_count", en_log.size(), 4);
    if (en_log.size() == 4)
      for (int i = 1; i < 4; i++) chk("b2b_period", en_log[i] - en_log[i-1], 8);

    // full / overflow with done withheld
    s_lat = 1000;
    push1(16'($urandom));
    run(3);
    for (int i = 0; i < 10; i++) push1(16'($urandom));
    run(1);
    chk("ovf_level", fifo_level, 8);
    chk("ovf_ready", adc_ready, 0);
    chk("ovf_flag", overflow, 1);
    s_valid = 1; s_clr = 1; s_data = 16'hdead; tick();
    s_valid = 0; s_clr = 0; run(1);
    chk("ovf_set_beats_clr", overflow, 1);
    s_clr = 1; tick(); s_clr = 0; run(1);
    chk("ovf_cleared", overflow, 0);
    s_lat = 2;
    run(90);

    // configuration request raised while a sample is in flight
    s_lat = 8;
    for (int i = 0; i < 3; i++) push1(16'($urandom));
    run(4);
    en_log.delete();
    s_cfg = 1;
    run(20);
    chk("cfg_no_enable", en_log.size(), 0);
    chk("cfg_line_high", fir_configuration, 1);
    chk("cfg_buffer_intact", fifo_level, 2);
    s_cfg = 0;
    run(30);
    chk("cfg_resume_count", en_log.size(), 2);

    // reset while waiting for done with samples buffered
    s_lat = 1000;
    for (int i = 0; i < 4; i++) push1(16'($urandom));
    run(3);
    s_rst = 1; tick(); s_rst = 0;
    en_log.delete();
    run(10);
    chk("rst_no_enable", en_log.size(), 0);
    chk("rst_level", fifo_level, 0);
    s_lat = 3;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      s_valid = ($urandom_range(0, 1) == 1);
      s_data  = 16'($urandom);
      if ($urandom_range(0, 24) == 0) s_cfg = !s_cfg;
      s_clr  = ($urandom_range(0, 15) == 0);
      s_spur = ($urandom_range(0, 9) == 0);
      if (i % 13 == 0) s_lat = $urandom_range(1, 8);
      tick();
    end
    s_valid = 0; s_cfg = 0; s_clr = 0; s_spur = 0; s_lat = 2;
    run(100);
    s_clr = 1; tick(); s_clr = 0;

    // done withheld long enough for the watchdog
    en_log.delete();
    s_lat = 100000;
    push1(16'h00a5);
    push1(16'h005a);
    run(80);
`ifdef FEEDER_TIMEOUT_EN
    chk("wd_timeout_err", timeout_err, 1);
    chk("wd_next_issued", en_log.size(), 2);
`else
    chk("wd_no_timeout_err", timeout_err, 0);
    chk("wd_still_waiting", en_log.size(), 1);
    chk("wd_level_held", fifo_level, 1);
`endif
    s_lat = 2;
    run(80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
